// File: rtl/rtc_set_ctrl.sv
// rtl/rtc_set_ctrl.sv - RTC time-set sequencer with 1 Hz tick prescaler
//
// Ports:
//   clk, reset (async, active-low)
//   btn_mode, btn_inc        debounced, clk-synchronous level buttons
//   cur_hr_m/l, cur_min_m/l  current BCD time from the RTC counter
//   tick                     one-cycle second-advance enable (RUN only)
//   load                     one-cycle strobe: RTC loads set_*, clears seconds
//   set_hr_m/l, set_min_m/l  edited BCD time, also shown while editing
//   mode                     0 = RUN, 1 = SET_HR, 2 = SET_MIN
//   blink                    display blink phase while editing
module rtc_set_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_hr_m,
  input  logic [3:0] cur_hr_l,
  input  logic [3:0] cur_min_m,
  input  logic [3:0] cur_min_l,
  output logic       tick,
  output logic       load,
  output logic [3:0] set_hr_m,
  output logic [3:0] set_hr_l,
  output logic [3:0] set_min_m,
  output logic [3:0] set_min_l,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int CW   = $clog2(TICK_DIV);
  localparam int HALF = TICK_DIV / 2;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  state_t        state, next_state;
  logic          btn_mode_q, btn_inc_q;
  logic          press_mode, press_inc;
  logic [CW-1:0] cnt, bcnt;

  logic          hr_valid, min_valid;
  logic [3:0]    hr_inc_m, hr_inc_l, min_inc_m, min_inc_l;

  assign press_mode = btn_mode & ~btn_mode_q;
  assign press_inc  = btn_inc  & ~btn_inc_q;
  assign mode       = state;

  // Out-of-range captures (e.g. RTC not yet initialised) start the edit at 00.
  assign hr_valid  = ((cur_hr_m < 4'd2) && (cur_hr_l <= 4'd9)) ||
                     ((cur_hr_m == 4'd2) && (cur_hr_l <= 4'd3));
  assign min_valid = (cur_min_m <= 4'd5) && (cur_min_l <= 4'd9);

  always_comb begin
    hr_inc_m = set_hr_m;
    hr_inc_l = set_hr_l + 4'd1;
    if (set_hr_m == 4'd2 && set_hr_l == 4'd3) begin
      hr_inc_m = 4'd0;
      hr_inc_l = 4'd0;
    end else if (set_hr_l == 4'd9) begin
      hr_inc_m = set_hr_m + 4'd1;
      hr_inc_l = 4'd0;
    end
  end

  always_comb begin
    min_inc_m = set_min_m;
    min_inc_l = set_min_l + 4'd1;
    if (set_min_l == 4'd9) begin
      min_inc_l = 4'd0;
      min_inc_m = (set_min_m == 4'd5) ? 4'd0 : set_min_m + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (press_mode) next_state = SET_HR;
      SET_HR:  if (press_mode) next_state = SET_MIN;
      SET_MIN: if (press_mode) next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_mode_q <= 1'b0;
      btn_inc_q  <= 1'b0;
      cnt        <= '0;
      bcnt       <= '0;
      tick       <= 1'b0;
      load       <= 1'b0;
      blink      <= 1'b0;
      set_hr_m   <= 4'd0;
      set_hr_l   <= 4'd0;
      set_min_m  <= 4'd0;
      set_min_l  <= 4'd0;
    end else begin
      btn_mode_q <= btn_mode;
      btn_inc_q  <= btn_inc;

      // Prescaler only runs while staying in RUN; the exit edge already
      // parks it at 0 so no tick can coincide with the edit entry.
      if (state == RUN && next_state == RUN) begin
        if (cnt == CW'(TICK_DIV - 1)) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt  <= cnt + CW'(1);
          tick <= 1'b0;
        end
      end else begin
        cnt  <= '0;
        tick <= 1'b0;
      end

      load <= (state == SET_MIN) && press_mode;

      if (next_state == RUN) begin
        blink <= 1'b0;
        bcnt  <= '0;
      end else if (state == RUN) begin
        blink <= 1'b1;
        bcnt  <= '0;
      end else if (bcnt == CW'(HALF - 1)) begin
        blink <= ~blink;
        bcnt  <= '0;
      end else begin
        bcnt  <= bcnt + CW'(1);
      end

      // A mode press in the same cycle as an increment suppresses the increment.
      if (state == RUN && press_mode) begin
        set_hr_m  <= hr_valid  ? cur_hr_m  : 4'd0;
        set_hr_l  <= hr_valid  ? cur_hr_l  : 4'd0;
        set_min_m <= min_valid ? cur_min_m : 4'd0;
        set_min_l <= min_valid ? cur_min_l : 4'd0;
      end else if (state == SET_HR && !press_mode && press_inc) begin
        set_hr_m <= hr_inc_m;
        set_hr_l <= hr_inc_l;
      end else if (state == SET_MIN && !press_mode && press_inc) begin
        set_min_m <= min_inc_m;
        set_min_l <= min_inc_l;
      end
    end
  end

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// tb/tb_rtc_set_ctrl.sv - self-checking bench for rtc_set_ctrl
module tb_rtc_set_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc;
  logic [3:0] cur_hr_m, cur_hr_l, cur_min_m, cur_min_l;
  logic       tick, load, blink;
  logic [3:0] set_hr_m, set_hr_l, set_min_m, set_min_l;
  logic [1:0] mode;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model: time held as plain integers, timing as cycle counts.
  int m_mode, m_hr, m_min, m_run, m_set;
  bit m_pbm, m_pbi, m_load;

  rtc_set_ctrl #(.TICK_DIV(10)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hr_m(cur_hr_m), .cur_hr_l(cur_hr_l),
    .cur_min_m(cur_min_m), .cur_min_l(cur_min_l),
    .tick(tick), .load(load),
    .set_hr_m(set_hr_m), .set_hr_l(set_hr_l),
    .set_min_m(set_min_m), .set_min_l(set_min_l),
    .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_hr = 0; m_min = 0; m_run = 0; m_set = 0;
    m_pbm = 0; m_pbi = 0; m_load = 0;
  endtask

  task automatic model_edge();
    bit pm, pi;
    int h, mi;
    pm = btn_mode && !m_pbm;
    pi = btn_inc && !m_pbi;
    m_pbm = btn_mode;
    m_pbi = btn_inc;
    m_load = 0;
    case (m_mode)
      0: if (pm) begin
           h  = cur_hr_m * 10 + cur_hr_l;
           mi = cur_min_m * 10 + cur_min_l;
           m_hr  = (cur_hr_l <= 9 && h <= 23) ? h : 0;
           m_min = (cur_min_l <= 9 && cur_min_m <= 5) ? mi : 0;
           m_mode = 1; m_set = 0;
         end else m_run++;
      1: begin
           if (pm) m_mode = 2;
           else if (pi) m_hr = (m_hr + 1) % 24;
           m_set++;
         end
      default: if (pm) begin
           m_mode = 0; m_load = 1; m_run = 0;
         end else begin
           if (pi) m_min = (m_min + 1) % 60;
           m_set++;
         end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  task automatic press_mode_once();
    btn_mode = 1; step(); btn_mode = 0; step();
  endtask

  task automatic press_inc_once();
    btn_inc = 1; step(); btn_inc = 0; step();
  endtask

  task automatic test_reset();
    reset = 0; btn_mode = 0; btn_inc = 0;
    cur_hr_m = 0; cur_hr_l = 0; cur_min_m = 0; cur_min_l = 0;
    model_reset();
    #3;
    tests_run++;
    if ({tick, load, blink, mode, set_hr_m, set_hr_l, set_min_m, set_min_l} !== 27'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h want 0",
               {tick, load, blink, mode, set_hr_m, set_hr_l, set_min_m, set_min_l});
    end
    repeat (3) @(posedge clk);
    #1 reset = 1;
    for (int n = 1; n <= 30; n++) begin
      step();
      tests_run++;
      if (tick !== (n % 10 == 0) || load !== 1'b0 || mode !== 2'd0) begin
        tests_failed++;
        $display("FAIL reset_tick_cadence: cycle %0d tick=%b load=%b mode=%0d want tick=%b load=0 mode=0",
                 n, tick, load, mode, (n % 10 == 0));
      end
    end
  endtask

  task automatic test_set_hours();
    cur_hr_m = 1; cur_hr_l = 2; cur_min_m = 3; cur_min_l = 4;
    btn_mode = 1; step();
    tests_run++;
    if (mode !== 2'd1 || {set_hr_m, set_hr_l, set_min_m, set_min_l} !== 16'h1234 ||
        tick !== 1'b0 || blink !== 1'b1) begin
      tests_failed++;
      $display("FAIL enter_set_hr: mode=%0d set=%h tick=%b blink=%b want 1 1234 0 1",
               mode, {set_hr_m, set_hr_l, set_min_m, set_min_l}, tick, blink);
    end
    btn_mode = 0; step();
    repeat (13) press_inc_once();
    tests_run++;
    if ({set_hr_m, set_hr_l, set_min_m, set_min_l} !== 16'h0134 || tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL hour_wrap: set=%h tick=%b want 0134 0",
               {set_hr_m, set_hr_l, set_min_m, set_min_l}, tick);
    end
  endtask

  task automatic test_set_minutes();
    press_mode_once();
    tests_run++;
    if (mode !== 2'd2) begin
      tests_failed++;
      $display("FAIL enter_set_min: mode=%0d want 2", mode);
    end
    btn_inc = 1; repeat (20) step(); btn_inc = 0; step();
    tests_run++;
    if ({set_min_m, set_min_l} !== 8'h35) begin
      tests_failed++;
      $display("FAIL hold_single_inc: min=%h want 35", {set_min_m, set_min_l});
    end
    repeat (23) press_inc_once();
    tests_run++;
    if ({set_min_m, set_min_l} !== 8'h58) begin
      tests_failed++;
      $display("FAIL min_count_58: min=%h want 58", {set_min_m, set_min_l});
    end
    for (int k = 0; k < 3; k++) begin
      press_inc_once();
      tests_run++;
      if ({set_min_m, set_min_l} !== ((k == 0) ? 8'h59 : (k == 1) ? 8'h00 : 8'h01) ||
          {set_hr_m, set_hr_l} !== 8'h01) begin
        tests_failed++;
        $display("FAIL min_wrap step %0d: set=%h", k, {set_hr_m, set_hr_l, set_min_m, set_min_l});
      end
    end
  endtask

  task automatic test_commit();
    btn_mode = 1; step();
    tests_run++;
    if (mode !== 2'd0 || load !== 1'b1 || tick !== 1'b0 || blink !== 1'b0 ||
        {set_hr_m, set_hr_l, set_min_m, set_min_l} !== 16'h0101) begin
      tests_failed++;
      $display("FAIL commit_load: mode=%0d load=%b tick=%b blink=%b set=%h want 0 1 0 0 0101",
               mode, load, tick, blink, {set_hr_m, set_hr_l, set_min_m, set_min_l});
    end
    btn_mode = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      tests_run++;
      if (load !== 1'b0 || tick !== (k == 10) ||
          {set_hr_m, set_hr_l, set_min_m, set_min_l} !== 16'h0101) begin
        tests_failed++;
        $display("FAIL post_load_tick: k=%0d load=%b tick=%b set=%h want load=0 tick=%b set=0101",
                 k, load, tick, {set_hr_m, set_hr_l, set_min_m, set_min_l}, (k == 10));
      end
    end
  endtask

  task automatic test_simultaneous_and_capture();
    cur_hr_m = 0; cur_hr_l = 9; cur_min_m = 1; cur_min_l = 5;
    press_mode_once();
    btn_mode = 1; btn_inc = 1; step();
    tests_run++;
    if (mode !== 2'd2 || {set_hr_m, set_hr_l} !== 8'h09) begin
      tests_failed++;
      $display("FAIL simultaneous_press: mode=%0d hr=%h want 2 09", mode, {set_hr_m, set_hr_l});
    end
    btn_mode = 0; btn_inc = 0; step();
    press_mode_once();
    cur_hr_m = 2; cur_hr_l = 5; cur_min_m = 6; cur_min_l = 1;
    btn_mode = 1; step();
    tests_run++;
    if (mode !== 2'd1 || {set_hr_m, set_hr_l, set_min_m, set_min_l} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL invalid_capture: mode=%0d set=%h want 1 0000",
               mode, {set_hr_m, set_hr_l, set_min_m, set_min_l});
    end
    btn_mode = 0; step();
  endtask

  task automatic test_async_reset();
    press_mode_once();
    press_inc_once();
    #2 reset = 0;
    #1;
    tests_run++;
    if ({tick, load, blink, mode, set_hr_m, set_hr_l, set_min_m, set_min_l} !== 27'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got %h want 0",
               {tick, load, blink, mode, set_hr_m, set_hr_l, set_min_m, set_min_l});
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1;
    for (int n = 1; n <= 25; n++) begin
      step();
      tests_run++;
      if (tick !== (n % 10 == 0) || load !== 1'b0 || mode !== 2'd0) begin
        tests_failed++;
        $display("FAIL after_reset: cycle %0d tick=%b load=%b mode=%0d want tick=%b load=0 mode=0",
                 n, tick, load, mode, (n % 10 == 0));
      end
    end
  endtask

  task automatic test_random();
    logic [26:0] exp_v;
    for (int n = 0; n < 600; n++) begin
      btn_mode  = ($urandom_range(0, 9) == 0);
      btn_inc   = ($urandom_range(0, 2) == 0);
      cur_hr_m  = 4'($urandom_range(0, 3));
      cur_hr_l  = 4'($urandom_range(0, 11));
      cur_min_m = 4'($urandom_range(0, 7));
      cur_min_l = 4'($urandom_range(0, 11));
      step();
      exp_v = {(m_mode == 0 && m_run > 0 && m_run % 10 == 0), m_load,
               (m_mode != 0 && (m_set / 5) % 2 == 0), 2'(m_mode),
               4'(m_hr / 10), 4'(m_hr % 10), 4'(m_min / 10), 4'(m_min % 10)};
      tests_run++;
      if ({tick, load, blink, mode, set_hr_m, set_hr_l, set_min_m, set_min_l} !== exp_v) begin
        tests_failed++;
        $display("FAIL random cycle %0d: tick/load/blink/mode/set got %h want %h", n,
                 {tick, load, blink, mode, set_hr_m, set_hr_l, set_min_m, set_min_l}, exp_v);
      end
    end
    btn_mode = 0; btn_inc = 0;
  endtask

  initial begin
    test_reset();
    test_set_hours();
    test_set_minutes();
    test_commit();
    test_simultaneous_and_capture();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rtc_set_ctrl.md
Name: rtc_set_ctrl

Overview:
- Time-keeping controller that sequences the BCD real-time-clock counter.
- Generates the 1 Hz advance enable from the system clock.
- Runs a two-button time-set state machine: edit hours, then minutes, then commit with a one-cycle load strobe.
- Sits between the board push-buttons and the RTC counter. Its set_* outputs also drive the seven-segment path while editing.

Parameters:
- TICK_DIV, 50000000: clk cycles per second tick. Must be even and >= 4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- btn_mode  in  1  mode button, already debounced and synchronous to clk, level.
- btn_inc  in  1  increment button, already debounced and synchronous to clk, level.
- cur_hr_m  in  4  current hour tens (BCD) from the RTC.
- cur_hr_l  in  4  current hour units (BCD) from the RTC.
- cur_min_m  in  4  current minute tens (BCD) from the RTC.
- cur_min_l  in  4  current minute units (BCD) from the RTC.
- tick  out  1  one-cycle second-advance enable to the RTC.
- load  out  1  one-cycle strobe: RTC loads set_* and clears seconds.
- set_hr_m  out  4  edited hour tens (BCD).
- set_hr_l  out  4  edited hour units (BCD).
- set_min_m  out  4  edited minute tens (BCD).
- set_min_l  out  4  edited minute units (BCD).
- mode  out  2  0 = RUN, 1 = SET_HR, 2 = SET_MIN (3 never driven).
- blink  out  1  display blink phase for the field being edited.

Behaviour:
- Reset (reset=0, async):
  - mode=RUN; tick=0, load=0, blink=0; all set_* = 0.
  - Prescaler, blink counter and button history regs = 0.
  - An edit in progress is discarded and no load is issued.
- Button edge detect:
  - press_x = btn_x & ~btn_x_q, with btn_x_q registered each cycle.
  - Each press acts once; holding a button gives exactly one action.
- Prescaler:
  - cnt counts 0..TICK_DIV-1 in RUN only.
  - tick=1 (registered) in the cycle after cnt==TICK_DIV-1, then cnt wraps to 0.
  - In SET_HR/SET_MIN: cnt held at 0, tick=0.
  - On return to RUN, cnt restarts from 0, so the first tick arrives TICK_DIV cycles after load.
- FSM, evaluated on the press edge; effects registered, visible the next cycle:
  - RUN + press_mode -> SET_HR.
    - Captures cur_* into set_*.
    - Hour captured as 00 if not a valid 00..23 BCD; minute captured as 00 if not a valid 00..59 BCD.
    - blink=1 and the blink counter restarts.
  - SET_HR + press_mode -> SET_MIN. Blink continues without restart.
  - SET_MIN + press_mode -> RUN.
    - load=1 for exactly the first RUN cycle; set_* hold their value during and after load.
    - blink=0.
  - press_inc in RUN: ignored.
- Increment rules:
  - SET_HR: hour+1 in BCD (09->10, 19->20, 23->00).
  - SET_MIN: minute+1 in BCD (09->10, 59->00). No carry into hour.
- Simultaneous press_mode and press_inc in the same cycle: mode transition wins, the increment is dropped.
- Blink: in set states, toggles every TICK_DIV/2 cycles; 0 in RUN.
- tick and load are never high in the same cycle.

Test Plan (TICK_DIV=10):
- Release reset, hold buttons low -> mode=0; tick pulses for exactly 1 cycle at the 10th, 20th and 30th clk edge after release; load=0; set_*=0.
- In RUN, cur=12:34, one press of btn_mode -> next cycle mode=1, set=12:34, tick stays 0. Then 13 separate btn_inc presses -> set_hr=01, set_min=34.
- In SET_MIN with set_min=58, btn_inc pressed 3 times -> 59, 00, 01; set_hr unchanged. Holding btn_inc high 20 cycles -> exactly one increment.
- From SET_MIN with set=01:01, press btn_mode -> mode=0, load=1 for exactly one cycle with set=01:01; first tick exactly 10 cycles after the load cycle.
- In SET_HR with set_hr=09, btn_mode and btn_inc rise in the same cycle -> mode=2, set_hr stays 09. Capture with cur_hr=25, cur_min=61 -> set=00:00.
- Assert reset low during SET_MIN -> all outputs 0 immediately, without a clock edge. After release: mode=0, no load pulse, ticks resume on the normal 10-cycle cadence.
